// File: rtl/universal_shift_reg_n.sv
// universal_shift_reg_n: parametrised universal shift register with rotate/arithmetic modes
// and a counted burst engine (start -> N shifts -> one-cycle done).
module universal_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] step_count,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             shift_left_input,
    input  logic             shift_right_input,
    output logic [WIDTH-1:0] out,
    output logic             serial_out_left,
    output logic             serial_out_right,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_n;
    logic [2:0]       mode_q, mode_q_n, op_mode;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] shifted;
    logic             is_shift, apply;
    assign is_shift = mode inside {3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
    assign op_mode  = (state == RUN) ? mode_q : mode;
    always_comb begin
        case (op_mode)
            3'b001:  shifted = {shift_right_input, out[WIDTH-1:1]};
            3'b010:  shifted = {out[WIDTH-2:0], shift_left_input};
            3'b011:  shifted = parallel_in;
            3'b100:  shifted = {out[0], out[WIDTH-1:1]};
            3'b101:  shifted = {out[WIDTH-2:0], out[WIDTH-1]};
            3'b110:  shifted = {out[WIDTH-1], out[WIDTH-1:1]};
            default: shifted = out;
        endcase
    end
    // A zero-length shift burst skips the operation but still reports done.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        mode_q_n = mode_q;
        apply    = 1'b0;
        case (state)
            IDLE: begin
                apply = !(start && is_shift && step_count == '0);
                if (start) begin
                    state_n = (is_shift && step_count > CNT_W'(1)) ? RUN : DONE;
                    if (is_shift && step_count != '0) begin
                        mode_q_n = mode;
                        cnt_n    = step_count - CNT_W'(1);
                    end
                end
            end
            RUN: begin
                apply = 1'b1;
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= '0;
            out    <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            mode_q <= mode_q_n;
            out    <= apply ? shifted : out;
        end
    end
    assign serial_out_left  = out[WIDTH-1];
    assign serial_out_right = out[0];
    assign busy             = (state == RUN);
    assign done             = (state == DONE);
endmodule

// File: tb/tb_universal_shift_reg_n.sv
// tb_universal_shift_reg_n: directed test-plan steps followed by random traffic,
// checked against an arithmetic reference model of the register and burst engine.
module tb_universal_shift_reg_n;
    localparam int W = 8;
    localparam int CW = 4;
    logic          clk = 1'b0;
    logic          rst, start, sli, sri;
    logic [2:0]    mode;
    logic [CW-1:0] sc;
    logic [W-1:0]  pin;
    logic [W-1:0]  out;
    logic          sol, sor, busy, done;
    int            errors = 0;
    int            checks = 0;
    int            m_val = 0, m_left = 0, m_mode = 0;
    bit            m_done = 0;
    int            done_seen;

    universal_shift_reg_n #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .step_count(sc),
        .parallel_in(pin), .shift_left_input(sli), .shift_right_input(sri),
        .out(out), .serial_out_left(sol), .serial_out_right(sor),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int op(int m, int v);
        case (m)
            1:       return (v >> 1) | (int'(sri) << (W - 1));
            2:       return ((v << 1) & 255) | int'(sli);
            3:       return int'(pin);
            4:       return (v >> 1) | ((v & 1) << (W - 1));
            5:       return ((v << 1) & 255) | (v >> (W - 1));
            6:       return (v >> 1) | (v & 128);
            default: return v;
        endcase
    endfunction

    function automatic bit is_shift(int m);
        return m == 1 || m == 2 || m == 4 || m == 5 || m == 6;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_val = 0; m_left = 0; m_mode = 0; m_done = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_left > 0) begin
            m_val = op(m_mode, m_val);
            m_left--;
            m_done = (m_left == 0);
        end else if (start) begin
            if (is_shift(int'(mode)) && sc != 0) begin
                m_val = op(int'(mode), m_val);
                m_mode = int'(mode);
                m_left = int'(sc) - 1;
                m_done = (sc == 1);
            end else begin
                if (!is_shift(int'(mode))) m_val = op(int'(mode), m_val);
                m_done = 1;
            end
        end else begin
            m_val = op(int'(mode), m_val);
        end
    endtask

    task automatic cyc(input logic r, input logic [2:0] md, input logic st, input logic [CW-1:0] n,
                       input logic [W-1:0] p, input logic l, input logic rr);
        rst = r; mode = md; start = st; sc = n; pin = p; sli = l; sri = rr;
        @(posedge clk);
        model_edge();
        #1;
        check("out", 32'(out), 32'(m_val));
        check("busy", 32'(busy), 32'(m_left > 0));
        check("done", 32'(done), 32'(m_done));
        check("sol", 32'(sol), 32'((m_val >> (W - 1)) & 1));
        check("sor", 32'(sor), 32'(m_val & 1));
        if (done) done_seen++;
    endtask

    initial begin
        rst = 1; mode = 0; start = 0; sc = 0; pin = 0; sli = 0; sri = 0;
        // Reset dominates a parallel load
        cyc(1, 3'b011, 0, 0, 8'hFF, 0, 0);
        cyc(1, 3'b011, 0, 0, 8'hFF, 0, 0);
        check("reset_out", 32'(out), 32'h00);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        cyc(0, 3'b011, 0, 0, 8'hFF, 0, 0);
        check("load_ff", 32'(out), 32'hFF);
        // Legacy free-running shifts
        repeat (3) cyc(0, 3'b010, 0, 0, 0, 0, 0);
        check("shl_f8", 32'(out), 32'hF8);
        cyc(0, 3'b011, 0, 0, 8'h00, 0, 0);
        repeat (2) cyc(0, 3'b001, 0, 0, 0, 0, 1);
        check("shr_c0", 32'(out), 32'hC0);
        // Rotate-left burst of 3 with the mode changed mid-burst
        cyc(0, 3'b011, 0, 0, 8'b1000_0001, 0, 0);
        done_seen = 0;
        cyc(0, 3'b101, 1, 3, 0, 0, 0);
        check("rot_busy1", 32'(busy), 1);
        cyc(0, 3'b001, 0, 0, 0, 1, 1);
        check("rot_busy2", 32'(busy), 1);
        cyc(0, 3'b011, 0, 0, 8'h55, 1, 1);
        check("rot_out", 32'(out), 32'h0C);
        check("rot_done", 32'(done), 1);
        cyc(0, 3'b000, 0, 0, 0, 0, 0);
        check("rot_done_once", 32'(done_seen), 1);
        // Arithmetic shift bursts
        cyc(0, 3'b011, 0, 0, 8'h90, 0, 0);
        cyc(0, 3'b110, 1, 2, 0, 0, 0);
        cyc(0, 3'b000, 0, 0, 0, 0, 0);
        check("asr2_out", 32'(out), 32'hE4);
        check("asr2_done", 32'(done), 1);
        cyc(0, 3'b000, 0, 0, 0, 0, 0);
        cyc(0, 3'b011, 0, 0, 8'h90, 0, 0);
        cyc(0, 3'b110, 1, 9, 0, 0, 0);
        repeat (8) cyc(0, 3'b000, 0, 0, 0, 0, 0);
        check("asr9_out", 32'(out), 32'hFF);
        check("asr9_done", 32'(done), 1);
        cyc(0, 3'b000, 0, 0, 0, 0, 0);
        // Zero-length burst: nothing shifts, done follows
        cyc(0, 3'b011, 0, 0, 8'hA5, 0, 0);
        cyc(0, 3'b001, 1, 0, 0, 1, 1);
        check("zero_out", 32'(out), 32'hA5);
        check("zero_done", 32'(done), 1);
        cyc(0, 3'b000, 0, 0, 0, 0, 0);
        // Start retriggered during RUN is ignored
        done_seen = 0;
        cyc(0, 3'b101, 1, 4, 0, 0, 0);
        cyc(0, 3'b010, 1, 2, 0, 0, 0);
        repeat (5) cyc(0, 3'b000, 0, 0, 0, 0, 0);
        check("retrig_done_once", 32'(done_seen), 1);
        check("retrig_out", 32'(out), 32'h5A);
        // Reset mid-burst aborts without a done pulse
        done_seen = 0;
        cyc(0, 3'b100, 1, 7, 0, 0, 0);
        cyc(0, 3'b000, 0, 0, 0, 0, 0);
        cyc(1, 3'b000, 0, 0, 0, 0, 0);
        check("abort_out", 32'(out), 0);
        check("abort_busy", 32'(busy), 0);
        repeat (4) cyc(0, 3'b000, 0, 0, 0, 0, 0);
        check("abort_no_done", 32'(done_seen), 0);
        // Random traffic
        for (int i = 0; i < 600; i++)
            cyc(($urandom % 60) == 0, 3'($urandom), ($urandom % 5) == 0, CW'($urandom),
                W'($urandom), 1'($urandom), 1'($urandom));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
